cc_reg_bank_decoder: RTL and testbench

//  Register bank and read-address decoder directly upstream of the one-hot register read mux.

---
 rtl/cc_reg_bank_decoder_pkg.sv | 22 ++
 rtl/cc_reg_bank_decoder_addr.sv | 22 ++
 rtl/cc_reg_bank_decoder.sv | 103 ++++++++++
 tb/tb_cc_reg_bank_decoder.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/cc_reg_bank_decoder_pkg.sv
// Shared constants for the register bank, its address decoders and the downstream read mux.
package cc_reg_bank_decoder_pkg;

    localparam int CC_REG_COUNT     = 38;
    localparam int CC_REG_ADDR_W    = 6;
    localparam int CC_DATAWIDTH_BUS = 32;

    // Named register indices; 32..37 are the special-purpose registers
    localparam int CC_REG_R0_ZERO   = 0;
    localparam int CC_REG_SPEC0     = 32;
    localparam int CC_REG_SPEC1     = 33;
    localparam int CC_REG_SPEC2     = 34;
    localparam int CC_REG_SPEC3     = 35;
    localparam int CC_REG_SPEC4     = 36;
    localparam int CC_REG_SPEC5     = 37;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } cc_sel_state_t;

endpackage

// File: rtl/cc_reg_bank_decoder_addr.sv
// Binary-to-one-hot converter; out-of-range indices yield all zeros and raise o_err.
module cc_reg_addr_decoder
    import cc_reg_bank_decoder_pkg::*;
#(
    parameter int N  = CC_REG_COUNT,
    parameter int AW = CC_REG_ADDR_W
) (
    input  logic [AW-1:0] i_addr,
    output logic [N-1:0]  o_onehot,
    output logic          o_err
);

    localparam logic [AW-1:0] ADDR_LIM = AW'(N);

    always_comb begin
        o_onehot = '0;
        o_err    = (i_addr >= ADDR_LIM);
        if (!o_err)
            o_onehot[i_addr] = 1'b1;
    end

endmodule

// File: rtl/cc_reg_bank_decoder.sv
// Register bank with flat read-out, guarded write port and registered one-hot A/B read selections.
module cc_reg_bank_decoder
    import cc_reg_bank_decoder_pkg::*;
#(
    parameter int DATAWIDTH_BUS         = CC_DATAWIDTH_BUS,
    parameter int DATAWIDTH_DECODER_OUT = CC_REG_COUNT,
    parameter int DATAWIDTH_ADDR        = CC_REG_ADDR_W
) (
    input  logic                                            CC_REG_BANK_CLOCK_50,
    input  logic                                            CC_REG_BANK_RESET_InHigh,
    input  logic [DATAWIDTH_ADDR-1:0]                       CC_REG_BANK_ADDR_A,
    input  logic [DATAWIDTH_ADDR-1:0]                       CC_REG_BANK_ADDR_B,
    input  logic [DATAWIDTH_ADDR-1:0]                       CC_REG_BANK_ADDR_C,
    input  logic                                            CC_REG_BANK_WR_EN,
    input  logic [DATAWIDTH_BUS-1:0]                        CC_REG_BANK_WR_DATA,
    input  logic                                            CC_REG_BANK_SEL_REQ,
    output logic [DATAWIDTH_DECODER_OUT*DATAWIDTH_BUS-1:0]  CC_REG_BANK_REGS_OUT,
    output logic [DATAWIDTH_DECODER_OUT-1:0]                CC_REG_BANK_SEL_A,
    output logic [DATAWIDTH_DECODER_OUT-1:0]                CC_REG_BANK_SEL_B,
    output logic                                            CC_REG_BANK_SEL_VALID,
    output logic                                            CC_REG_BANK_ADDR_ERR
);

    localparam int                        N        = DATAWIDTH_DECODER_OUT;
    localparam int                        AW       = DATAWIDTH_ADDR;
    localparam logic [AW-1:0]             ADDR_LIM = AW'(N);
    localparam logic [AW-1:0]             ADDR_R0  = AW'(CC_REG_R0_ZERO);

    logic [N-1:0][DATAWIDTH_BUS-1:0] r_regs;
    logic [N-1:0]                    r_sel_a;
    logic [N-1:0]                    r_sel_b;
    logic                            r_sel_valid;
    logic                            r_addr_err;
    cc_sel_state_t                   r_state;

    logic [N-1:0] w_oh_a;
    logic [N-1:0] w_oh_b;
    logic         w_err_a;
    logic         w_err_b;
    logic         w_err_c;
    logic         w_wr_hit;
    logic         w_err_now;

    cc_reg_addr_decoder #(.N(N), .AW(AW)) u_dec_a (
        .i_addr   (CC_REG_BANK_ADDR_A),
        .o_onehot (w_oh_a),
        .o_err    (w_err_a)
    );

    cc_reg_addr_decoder #(.N(N), .AW(AW)) u_dec_b (
        .i_addr   (CC_REG_BANK_ADDR_B),
        .o_onehot (w_oh_b),
        .o_err    (w_err_b)
    );

    // R0 is never written, so it stays at its reset value of zero
    assign w_err_c   = (CC_REG_BANK_ADDR_C >= ADDR_LIM);
    assign w_wr_hit  = CC_REG_BANK_WR_EN && !w_err_c && (CC_REG_BANK_ADDR_C != ADDR_R0);
    assign w_err_now = (CC_REG_BANK_WR_EN && w_err_c) ||
                       (CC_REG_BANK_SEL_REQ && (w_err_a || w_err_b));

    always_ff @(posedge CC_REG_BANK_CLOCK_50) begin
        if (CC_REG_BANK_RESET_InHigh) begin
            r_regs      <= '0;
            r_sel_a     <= '0;
            r_sel_b     <= '0;
            r_sel_valid <= 1'b0;
            r_addr_err  <= 1'b0;
            r_state     <= ST_IDLE;
        end else begin
            if (w_wr_hit)
                r_regs[CC_REG_BANK_ADDR_C] <= CC_REG_BANK_WR_DATA;
            if (w_err_now)
                r_addr_err <= 1'b1;

            // SEL_VALID is high exactly while in PRESENT; selections hold in IDLE
            case (r_state)
                ST_IDLE, ST_PRESENT: begin
                    if (CC_REG_BANK_SEL_REQ) begin
                        r_sel_a     <= w_oh_a;
                        r_sel_b     <= w_oh_b;
                        r_sel_valid <= 1'b1;
                        r_state     <= ST_PRESENT;
                    end else begin
                        r_sel_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_sel_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign CC_REG_BANK_REGS_OUT  = r_regs;
    assign CC_REG_BANK_SEL_A     = r_sel_a;
    assign CC_REG_BANK_SEL_B     = r_sel_b;
    assign CC_REG_BANK_SEL_VALID = r_sel_valid;
    assign CC_REG_BANK_ADDR_ERR  = r_addr_err;

endmodule

// File: tb/tb_cc_reg_bank_decoder.sv
// Randomized and directed check of the register bank against a behavioural model.
module tb_cc_reg_bank_decoder;

    localparam int NREG = 38;
    localparam int DW   = 32;

    logic              clk;
    logic              rst;
    logic [5:0]        addr_a, addr_b, addr_c;
    logic              wr_en, sel_req;
    logic [DW-1:0]     wr_data;
    logic [NREG*DW-1:0] regs_out;
    logic [NREG-1:0]   sel_a, sel_b;
    logic              sel_valid, addr_err;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model
    logic [DW-1:0]   m_regs [NREG];
    logic [NREG-1:0] m_sel_a, m_sel_b;
    logic            m_valid, m_err;

    cc_reg_bank_decoder dut (
        .CC_REG_BANK_CLOCK_50     (clk),
        .CC_REG_BANK_RESET_InHigh (rst),
        .CC_REG_BANK_ADDR_A       (addr_a),
        .CC_REG_BANK_ADDR_B       (addr_b),
        .CC_REG_BANK_ADDR_C       (addr_c),
        .CC_REG_BANK_WR_EN        (wr_en),
        .CC_REG_BANK_WR_DATA      (wr_data),
        .CC_REG_BANK_SEL_REQ      (sel_req),
        .CC_REG_BANK_REGS_OUT     (regs_out),
        .CC_REG_BANK_SEL_A        (sel_a),
        .CC_REG_BANK_SEL_B        (sel_b),
        .CC_REG_BANK_SEL_VALID    (sel_valid),
        .CC_REG_BANK_ADDR_ERR     (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [NREG-1:0] onehot(input int a);
        logic [NREG-1:0] v;
        v = '0;
        if (a < NREG) v[a] = 1'b1;
        return v;
    endfunction

    function automatic logic [DW-1:0] word(input int k);
        return regs_out[k*DW +: DW];
    endfunction

    task automatic check_all(input string tag);
        for (int k = 0; k < NREG; k++)
            chk($sformatf("%s word%0d", tag, k), {32'h0, word(k)}, {32'h0, m_regs[k]});
        chk({tag, " sel_a"}, {26'h0, sel_a}, {26'h0, m_sel_a});
        chk({tag, " sel_b"}, {26'h0, sel_b}, {26'h0, m_sel_b});
        chk({tag, " sel_valid"}, {63'h0, sel_valid}, {63'h0, m_valid});
        chk({tag, " addr_err"}, {63'h0, addr_err}, {63'h0, m_err});
    endtask

    // Drive one cycle of stimulus, advance the model from the same inputs, then compare
    task automatic step(input string tag, input logic r, input logic we, input int c,
                        input logic [DW-1:0] d, input logic rq, input int a, input int b);
        rst = r; wr_en = we; addr_c = 6'(c); wr_data = d;
        sel_req = rq; addr_a = 6'(a); addr_b = 6'(b);
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < NREG; k++) m_regs[k] = '0;
            m_sel_a = '0; m_sel_b = '0; m_valid = 1'b0; m_err = 1'b0;
        end else begin
            if (we && c < NREG && c != 0) m_regs[c] = d;
            if (we && c >= NREG) m_err = 1'b1;
            if (rq) begin
                m_sel_a = onehot(a);
                m_sel_b = onehot(b);
                m_valid = 1'b1;
                if (a >= NREG || b >= NREG) m_err = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; sel_req = 1'b0;
        addr_a = '0; addr_b = '0; addr_c = '0; wr_data = '0;
        for (int k = 0; k < NREG; k++) m_regs[k] = '0;
        m_sel_a = '0; m_sel_b = '0; m_valid = 1'b0; m_err = 1'b0;

        // T1: reset wins over held write/select
        step("t1_rst", 1'b1, 1'b1, 5, 32'hAAAA5555, 1'b1, 3, 4);
        step("t1_rst2", 1'b1, 1'b1, 40, 32'h1, 1'b1, 45, 2);
        chk("t1 sel_a", {26'h0, sel_a}, 64'h0);
        chk("t1 err", {63'h0, addr_err}, 64'h0);

        // T2: write R5 then select A=5, B=0
        step("t2_wr", 1'b0, 1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 0);
        step("t2_sel", 1'b0, 1'b0, 0, 32'h0, 1'b1, 5, 0);
        chk("t2 sel_a", {26'h0, sel_a}, 64'h20);
        chk("t2 sel_b", {26'h0, sel_b}, 64'h1);
        chk("t2 valid", {63'h0, sel_valid}, 64'h1);
        chk("t2 word5", {32'h0, word(5)}, 64'hDEADBEEF);
        step("t2_idle", 1'b0, 1'b0, 0, 32'h0, 1'b0, 9, 9);
        chk("t2 valid_pulse", {63'h0, sel_valid}, 64'h0);

        // T3: R0 is hardwired zero and writing it is not an error
        step("t3_r0", 1'b0, 1'b1, 0, 32'hFFFFFFFF, 1'b0, 0, 0);
        chk("t3 word0", {32'h0, word(0)}, 64'h0);
        chk("t3 err", {63'h0, addr_err}, 64'h0);

        // T4: out-of-range A, top register B, sticky error
        step("t4_sel", 1'b0, 1'b0, 0, 32'h0, 1'b1, 40, 37);
        chk("t4 sel_a", {26'h0, sel_a}, 64'h0);
        chk("t4 sel_b", {26'h0, sel_b}, 64'h20_0000_0000);
        chk("t4 err", {63'h0, addr_err}, 64'h1);
        step("t4_hold", 1'b0, 1'b0, 0, 32'h0, 1'b0, 1, 1);
        chk("t4 err_sticky", {63'h0, addr_err}, 64'h1);

        // Out-of-range write: nothing changes
        step("wr_oor_rst", 1'b1, 1'b0, 0, 32'h0, 1'b0, 0, 0);
        step("wr_oor", 1'b0, 1'b1, 38, 32'h5A5A5A5A, 1'b0, 0, 0);
        chk("wr_oor err", {63'h0, addr_err}, 64'h1);

        // T5: same-cycle write and select of R37
        step("t5", 1'b0, 1'b1, 37, 32'h12345678, 1'b1, 37, 37);
        chk("t5 sel_a37", {63'h0, sel_a[37]}, 64'h1);
        chk("t5 word37", {32'h0, word(37)}, 64'h12345678);

        // T6: back-to-back requests then reset
        step("t6_a1", 1'b0, 1'b0, 0, 32'h0, 1'b1, 1, 2);
        chk("t6 sel_a1", {26'h0, sel_a}, 64'h2);
        step("t6_a2", 1'b0, 1'b0, 0, 32'h0, 1'b1, 2, 2);
        chk("t6 sel_a2", {26'h0, sel_a}, 64'h4);
        chk("t6 valid2", {63'h0, sel_valid}, 64'h1);
        step("t6_a3", 1'b0, 1'b0, 0, 32'h0, 1'b1, 3, 2);
        chk("t6 sel_a3", {26'h0, sel_a}, 64'h8);
        chk("t6 valid3", {63'h0, sel_valid}, 64'h1);
        step("t6_rst", 1'b1, 1'b1, 7, 32'hCAFEF00D, 1'b1, 4, 4);
        chk("t6 sel_a_rst", {26'h0, sel_a}, 64'h0);
        chk("t6 word37_rst", {32'h0, word(37)}, 64'h0);

        // Randomized traffic, addresses deliberately straddle the legal range
        for (int i = 0; i < 400; i++) begin
            step($sformatf("rnd%0d", i),
                 ($urandom_range(0, 59) == 0),
                 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 41)),
                 $urandom(),
                 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 43)),
                 int'($urandom_range(0, 43)));
            if ($countones(sel_a) > 1 || $countones(sel_b) > 1) begin
                n_chk++;
                n_fail++;
                $display("FAIL rnd%0d multihot: sel_a=0x%0h sel_b=0x%0h expected at most one bit", i, sel_a, sel_b);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
